// File: rtl/out_port_fifo_pkg.sv
// Shared processor constants for the OUT-port FIFO: word width, depth and derived widths.
package out_port_fifo_pkg;

  localparam int WORD_W         = 16;
  localparam int OUT_FIFO_DEPTH = 4;
  localparam int OUT_FIFO_PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int OUT_FIFO_CNT_W = OUT_FIFO_PTR_W + 1;

endpackage

// File: rtl/out_fifo_ram.sv
// FIFO storage array: synchronous write, asynchronous read, no reset on contents.
module out_fifo_ram
  import out_port_fifo_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = OUT_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// Processor OUT-port FIFO, first-word-fall-through, with legacy last-word mirror.
// Optional sticky overflow flag enabled by defining OUT_FIFO_OVERFLOW_FLAG_EN.
module out_port_fifo
  import out_port_fifo_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [WIDTH-1:0]         out_last,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ovf_clr,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             drop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
  assign push      = wr_en && (!full || pop);
  assign drop      = wr_en && full && !pop;

  out_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign out_data = empty ? '0 : head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_last <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        out_last <= wr_data;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr ^ drop;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed self-checking bench for out_port_fifo; expected overflow follows OUT_FIFO_OVERFLOW_FLAG_EN.
module tb_out_port_fifo;

`ifdef OUT_FIFO_OVERFLOW_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_last;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf_clr;
  logic        overflow;

  int compared;
  int mismatched;

  out_port_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    #12;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single write becomes visible one cycle later
    wr_en = 1'b1; wr_data = 16'h00A5;
    check("no_bypass_valid", 32'(out_valid), 32'd0);
    tick();
    wr_en = 1'b0;
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_data", 32'(out_data), 32'h00A5);
    check("w1_count", 32'(count), 32'd1);
    check("w1_last", 32'(out_last), 32'h00A5);
    out_ready = 1'b1;
    tick();
    check("pop1_empty", 32'(empty), 32'd1);
    check("pop1_data", 32'(out_data), 32'd0);
    tick();
    check("ready_empty_count", 32'(count), 32'd0);
    check("ready_empty_last", 32'(out_last), 32'h00A5);
    out_ready = 1'b0;

    // Fill to full, then drop a fifth write
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      tick();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    wr_data = 16'h0005;
    tick();
    wr_en = 1'b0;
    check("drop_count", 32'(count), 32'd4);
    check("drop_head", 32'(out_data), 32'h0001);
    check("drop_last", 32'(out_last), 32'h0004);
    check("drop_ovf", 32'(overflow), 32'(OVF_EN));

    // Push and pop together while full
    wr_en = 1'b1; wr_data = 16'h0009; out_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    check("pp_full_count", 32'(count), 32'd4);
    check("pp_full_last", 32'(out_last), 32'h0009);
    check("pop_seq0", 32'(out_data), 32'h0002);
    tick();
    check("pop_seq1", 32'(out_data), 32'h0003);
    tick();
    check("pop_seq2", 32'(out_data), 32'h0004);
    tick();
    check("pop_seq3", 32'(out_data), 32'h0009);
    tick();
    check("pop_seq_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'(OVF_EN));
    out_ready = 1'b0;

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Pointer wrap with one entry in flight for ten cycles
    wr_en = 1'b1; wr_data = 16'h0100;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 16'(16'h0101 + i);
      check($sformatf("wrap_data%0d", i), 32'(out_data), 32'(16'h0100 + i));
      tick();
      check($sformatf("wrap_count%0d", i), 32'(count), 32'd1);
    end
    wr_en = 1'b0;
    check("wrap_tail", 32'(out_data), 32'h010A);
    tick();
    check("wrap_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Drop and clear in the same cycle: drop wins
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 16'(16'h0200 + i);
      tick();
    end
    wr_data = 16'h02FF; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("drop_vs_clr", 32'(overflow), 32'(OVF_EN));
    check("drop_vs_clr_head", 32'(out_data), 32'h0200);

    // Pop one so count is 3, then reset asynchronously between edges
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_empty", 32'(empty), 32'd1);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_last", 32'(out_last), 32'd0);
    check("async_ovf", 32'(overflow), 32'd0);
    #2;
    rst = 1'b0;

    // First push accepted on the first edge after reset release
    wr_en = 1'b1; wr_data = 16'h0077;
    tick();
    wr_en = 1'b0;
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data word width; SHALL match the processor word.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; SHALL be a power of two and at least 2.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 wr_en  in  1  processor output-write strobe (OUT instruction in execute).
REQ-006 wr_data  in  WIDTH  word to emit (ALU result of the OUT instruction).
REQ-007 out_valid  out  1  head entry available to the external consumer.
REQ-008 out_ready  in  1  external consumer accepts the head entry.
REQ-009 out_data  out  WIDTH  head entry, first-word-fall-through.
REQ-010 out_last  out  WIDTH  last accepted word (legacy OUT-port mirror).
REQ-011 full  out  1  count == DEPTH.
REQ-012 empty  out  1  count == 0.
REQ-013 count  out  clog2(DEPTH)+1  occupancy.
REQ-014 ovf_clr  in  1  clears the sticky overflow flag.
REQ-015 overflow  out  1  sticky flag: a write was dropped.

Function
REQ-016 Push SHALL occur when wr_en=1 and (full=0 or a pop occurs in the same cycle).
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL equal !empty; out_data SHALL be the head entry combinationally and SHALL be 0 when empty.
REQ-019 A write into an empty FIFO SHALL raise out_valid one cycle later; there is no same-cycle bypass.
REQ-020 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH without a special case.
REQ-022 A write with full=1 and no pop SHALL be dropped, with storage, pointers and count unchanged.
REQ-023 out_last SHALL load wr_data on every accepted push and SHALL hold otherwise.
REQ-024 out_ready while empty SHALL have no effect.
REQ-025 Storage contents SHALL never be read outside the occupied range.

Reset
REQ-026 While rst=1, pointers, count, out_last and overflow SHALL be 0, and empty SHALL be 1; storage contents need not be cleared.
REQ-027 Assertion of rst mid-transfer SHALL discard all entries immediately (asynchronously), without waiting for a clock edge.
REQ-028 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro OUT_FIFO_OVERFLOW_FLAG_EN: when defined, a dropped write (REQ-022) SHALL set overflow.
REQ-030 With OUT_FIFO_OVERFLOW_FLAG_EN defined, ovf_clr SHALL clear overflow on the next edge; on a simultaneous drop and ovf_clr, the drop SHALL win.
REQ-031 Without OUT_FIFO_OVERFLOW_FLAG_EN, overflow SHALL be tied to 0, ovf_clr SHALL be ignored, and no flag flop SHALL be synthesized.

Structure
REQ-032 The shared processor package SHALL hold WORD_W=16, OUT_FIFO_DEPTH=4 and the derived pointer/count width constants.
REQ-033 Storage SHALL be a sub-module out_fifo_ram (DEPTH x WIDTH, synchronous write, asynchronous read); control logic SHALL stay in out_port_fifo.

Verification
REQ-034 Reset, then wr_en=1 with wr_data=0x00A5 for one cycle -> next cycle out_valid=1, out_data=0x00A5, count=1, out_last=0x00A5.
REQ-035 Four writes 0x0001..0x0004 with out_ready=0 -> full=1, count=4; a fifth write 0x0005 is dropped -> overflow=1 (macro defined) and out_data=0x0001.
REQ-036 Full FIFO with wr_en=1 (0x0009) and out_ready=1 in the same cycle -> count stays 4; the pop sequence is 0x0002, 0x0003, 0x0004, 0x0009.
REQ-037 Ten push/pop cycles at DEPTH=4 (pointer wrap) -> data stays in order and empty=1 at the end.
REQ-038 rst asserted with count=3 -> empty=1, out_valid=0, count=0 before the next clock edge.
REQ-039 Overflow set, then ovf_clr=1 for one cycle -> overflow=0; a build without the macro -> overflow stays 0 in REQ-035.
